hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Stall/flush controller for the MIPS pipeline. It is the consumer-side partner of the forwarding unit.
//  It detects the hazards that forwarding cannot resolve: load-use, and branch operands resolved in ID.
//  For these it freezes PC and IF/ID and inserts ID/EX bubbles. It flushes IF/ID on a taken branch.
//  On HALT it drains the pipeline with an FSM and reports completion to the debug unit.
// PARAMETERS
//  REG_ADDR_SIZE   5    register address width
//  DRAIN_CYCLES    3    cycles after HALT leaves ID until WB is empty (EX, MEM, WB)
//  STALL_CNT_SIZE  16   width of the saturating stall counter
// PORTS
//  i_clk              in   1    clock, rising edge
//  i_reset            in   1    asynchronous reset, active-low
//  i_enable           in   1    pipeline advance enable from debug unit; 0 freezes all state
//  i_id_rs            in   RAS  rs of the instruction in ID
//  i_id_rt            in   RAS  rt of the instruction in ID
//  i_id_is_branch     in   1    ID instruction compares operands (BEQ/BNE/JR/JALR)
//  i_id_branch_taken  in   1    branch/jump resolved taken in ID
//  i_id_halt          in   1    HALT instruction in ID
//  i_id_ex_mem_rd     in   1    instruction in EX is a load
//  i_id_ex_wb         in   1    instruction in EX writes the register file
//  i_id_ex_addr       in   RAS  destination register of the EX instruction
//  i_ex_mem_mem_rd    in   1    instruction in MEM is a load
//  i_ex_mem_addr      in   RAS  destination register of the MEM instruction
//  o_pc_stall         out  1    hold PC
//  o_if_id_stall      out  1    hold IF/ID
//  o_if_id_flush      out  1    zero IF/ID (taken branch)
//  o_id_ex_flush      out  1    insert a bubble into ID/EX
//  o_halted           out  1    pipeline fully drained after HALT
//  o_stall_count      out  SCS  saturating count of stall cycles, for debug readout
// BEHAVIOUR
//  Hazard terms (combinational from inputs). Register 0 never hazards:
//   LU  = i_id_ex_mem_rd & (i_id_ex_addr==i_id_rs | i_id_ex_addr==i_id_rt) & addr!=0
//   BEX = i_id_is_branch & i_id_ex_wb & match(i_id_ex_addr) & addr!=0
//   BMM = i_id_is_branch & i_ex_mem_mem_rd & match(i_ex_mem_addr) & addr!=0
//   STALL = state==RUN & i_enable & (LU | BEX | BMM)
//  STALL: o_pc_stall = o_if_id_stall = o_id_ex_flush = 1; o_if_id_flush = 0.
//   Stall has priority over i_id_branch_taken, because the branch was resolved on stale operands.
//  A load feeding a branch gives 2 stall cycles: LU, then BMM. This needs no extra state.
//  Taken branch with no STALL, state RUN: o_if_id_flush = 1 for that cycle only.
//  i_enable = 0: all outputs hold their combinational values except the STALL term, which is forced to 0.
//   FSM, drain counter and o_stall_count do not change.
//  FSM states, registered, encoded in the package:
//   RUN: HALT in ID with no STALL and i_enable -> DRAIN, drain_cnt <= DRAIN_CYCLES-1.
//     The HALT advances into EX. From this cycle on, o_pc_stall = o_if_id_stall = 1.
//     A HALT held in ID during a STALL is ignored until the stall clears.
//   DRAIN: o_pc_stall = o_if_id_stall = o_id_ex_flush = 1. drain_cnt decrements each enabled cycle.
//     At 0 -> HALTED. No hazard or branch output is asserted in DRAIN.
//   HALTED: o_halted = 1; PC, IF/ID stall and ID/EX flush held at 1. Exit only by reset.
//  o_halted is a registered output: 1 in the cycle after the DRAIN->HALTED transition.
//   Latency from HALT in ID to o_halted = 1 is DRAIN_CYCLES + 1 enabled cycles.
//  o_stall_count increments on every cycle where STALL = 1. It saturates at all-ones and does not wrap.
//  Reset (async, any state, including mid-DRAIN): state = RUN, drain_cnt = 0, o_stall_count = 0, o_halted = 0.
//   All combinational outputs then follow the inputs.
// STRUCTURE
//  Package hazard_stall_ctrl.vh: state codes (RUN/DRAIN/HALTED) and defaults.
//   The defaults are DRAIN_CYCLES, REG_ADDR_SIZE and STALL_CNT_SIZE.
//  Flat module: combinational hazard detect, 2-bit state register, drain down-counter, saturating counter.
//  No sub-module is needed.
// TESTING
//  1. LW $1 in EX; ID uses rs=1 -> one cycle with pc_stall/if_id_stall/id_ex_flush=1; stall_count=1.
//  2. LW $0 in EX; ID rs=0 -> no stall. EX writer $3 (non-load); ID ADD rs=3 -> no stall (forwarded).
//  3. BEQ rs=4 in ID; load to $4 in EX -> 2 stall cycles (LU, then BMM), then if_id_flush=1 if taken.
//  4. BEQ taken in ID with BEX hazard -> stall only, if_id_flush=0. Next cycle: flush=1, stall=0.
//  5. HALT in ID, DRAIN_CYCLES=3 -> o_halted=1 exactly 4 enabled cycles later.
//     Insert i_enable=0 for 2 cycles mid-DRAIN -> o_halted is delayed by 2 cycles.
//  6. Assert i_reset=0 mid-DRAIN -> o_halted=0 and all stalls released immediately.
//     Force 2^SCS+5 stall cycles -> stall_count saturates at all-ones.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared state encoding and parameter defaults for the pipeline stall/flush controller.
package hazard_stall_ctrl_pkg;

  localparam int unsigned DefRegAddrSize  = 5;
  localparam int unsigned DefDrainCycles  = 3;
  localparam int unsigned DefStallCntSize = 16;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller: resolves hazards forwarding cannot cover, flushes on taken branches,
// and drains the pipeline after HALT before reporting completion.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_SIZE  = DefRegAddrSize,
  parameter int unsigned DRAIN_CYCLES   = DefDrainCycles,
  parameter int unsigned STALL_CNT_SIZE = DefStallCntSize
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic [REG_ADDR_SIZE-1:0]  i_id_rs,
  input  logic [REG_ADDR_SIZE-1:0]  i_id_rt,
  input  logic                      i_id_is_branch,
  input  logic                      i_id_branch_taken,
  input  logic                      i_id_halt,
  input  logic                      i_id_ex_mem_rd,
  input  logic                      i_id_ex_wb,
  input  logic [REG_ADDR_SIZE-1:0]  i_id_ex_addr,
  input  logic                      i_ex_mem_mem_rd,
  input  logic [REG_ADDR_SIZE-1:0]  i_ex_mem_addr,
  output logic                      o_pc_stall,
  output logic                      o_if_id_stall,
  output logic                      o_if_id_flush,
  output logic                      o_id_ex_flush,
  output logic                      o_halted,
  output logic [STALL_CNT_SIZE-1:0] o_stall_count
);

  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES - 1);
  localparam logic [DrainW-1:0] DrainOne = DrainW'(1);
  localparam logic [STALL_CNT_SIZE-1:0] CntOne = STALL_CNT_SIZE'(1);

  state_e                    state_q, state_d;
  logic [DrainW-1:0]         drain_q, drain_d;
  logic [STALL_CNT_SIZE-1:0] cnt_q, cnt_d;
  logic                      halted_q;

  logic ex_match, mem_match;
  logic lu, bex, bmm, stall, halt_go;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign ex_match  = (i_id_ex_addr != '0) &&
                     ((i_id_ex_addr == i_id_rs) || (i_id_ex_addr == i_id_rt));
  assign mem_match = (i_ex_mem_addr != '0) &&
                     ((i_ex_mem_addr == i_id_rs) || (i_ex_mem_addr == i_id_rt));

  assign lu      = i_id_ex_mem_rd & ex_match;
  assign bex     = i_id_is_branch & i_id_ex_wb & ex_match;
  assign bmm     = i_id_is_branch & i_ex_mem_mem_rd & mem_match;
  assign stall   = (state_q == StRun) & i_enable & (lu | bex | bmm);
  assign halt_go = i_id_halt & ~stall;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= StRun;
      drain_q  <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == StHalted);
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      StRun: begin
        if (i_enable && halt_go) begin
          state_d = StDrain;
          drain_d = DrainLoad;
        end
      end
      StDrain: begin
        if (i_enable) begin
          if (drain_q == '0) begin
            state_d = StHalted;
          end else begin
            drain_d = drain_q - DrainOne;
          end
        end
      end
      StHalted: ;
      default: state_d = StRun;
    endcase
  end

  // Saturate rather than wrap so a long stall storm never reads back as a small count.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_comb begin
    o_pc_stall    = 1'b0;
    o_if_id_stall = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    unique case (state_q)
      StRun: begin
        // Stall wins over a taken branch: the branch compared stale operands.
        o_pc_stall    = stall | halt_go;
        o_if_id_stall = stall | halt_go;
        o_id_ex_flush = stall;
        o_if_id_flush = i_id_branch_taken & ~stall;
      end
      StDrain, StHalted: begin
        o_pc_stall    = 1'b1;
        o_if_id_stall = 1'b1;
        o_id_ex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_halted      = halted_q;
  assign o_stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl with hand-computed expectations.
module tb_hazard_stall_ctrl;

  localparam int unsigned Ras = 5;
  localparam int unsigned Scs = 4;

  logic           i_clk = 1'b0;
  logic           i_reset;
  logic           i_enable;
  logic [Ras-1:0] i_id_rs, i_id_rt, i_id_ex_addr, i_ex_mem_addr;
  logic           i_id_is_branch, i_id_branch_taken, i_id_halt;
  logic           i_id_ex_mem_rd, i_id_ex_wb, i_ex_mem_mem_rd;
  logic           o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_flush, o_halted;
  logic [Scs-1:0] o_stall_count;
  logic [4:0]     ctl;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 i_clk = ~i_clk;

  hazard_stall_ctrl #(
    .REG_ADDR_SIZE (Ras),
    .DRAIN_CYCLES  (3),
    .STALL_CNT_SIZE(Scs)
  ) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_enable         (i_enable),
    .i_id_rs          (i_id_rs),
    .i_id_rt          (i_id_rt),
    .i_id_is_branch   (i_id_is_branch),
    .i_id_branch_taken(i_id_branch_taken),
    .i_id_halt        (i_id_halt),
    .i_id_ex_mem_rd   (i_id_ex_mem_rd),
    .i_id_ex_wb       (i_id_ex_wb),
    .i_id_ex_addr     (i_id_ex_addr),
    .i_ex_mem_mem_rd  (i_ex_mem_mem_rd),
    .i_ex_mem_addr    (i_ex_mem_addr),
    .o_pc_stall       (o_pc_stall),
    .o_if_id_stall    (o_if_id_stall),
    .o_if_id_flush    (o_if_id_flush),
    .o_id_ex_flush    (o_id_ex_flush),
    .o_halted         (o_halted),
    .o_stall_count    (o_stall_count)
  );

  // {pc_stall, if_id_stall, if_id_flush, id_ex_flush, halted}
  assign ctl = {o_pc_stall, o_if_id_stall, o_if_id_flush, o_id_ex_flush, o_halted};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_enable          = 1'b1;
    i_id_rs           = '0;
    i_id_rt           = '0;
    i_id_is_branch    = 1'b0;
    i_id_branch_taken = 1'b0;
    i_id_halt         = 1'b0;
    i_id_ex_mem_rd    = 1'b0;
    i_id_ex_wb        = 1'b0;
    i_id_ex_addr      = '0;
    i_ex_mem_mem_rd   = 1'b0;
    i_ex_mem_addr     = '0;
  endtask

  initial begin
    idle();
    i_reset = 1'b0;
    #3;
    check("rst_ctl", 32'(ctl), 32'h00);
    check("rst_cnt", 32'(o_stall_count), 0);
    step();
    step();
    i_reset = 1'b1;
    #1;

    // Load-use on rs
    idle(); i_id_ex_mem_rd = 1; i_id_ex_addr = 1; i_id_rs = 1; #1;
    check("lu_rs", 32'(ctl), 32'b11010);
    step();
    check("lu_cnt", 32'(o_stall_count), 1);
    idle(); #1;
    check("lu_clear", 32'(ctl), 32'b00000);

    // Register 0 and a forwardable ALU producer
    i_id_ex_mem_rd = 1; i_id_ex_addr = 0; i_id_rs = 0; #1;
    check("r0_load", 32'(ctl), 32'b00000);
    idle(); i_id_ex_wb = 1; i_id_ex_addr = 3; i_id_rs = 3; #1;
    check("fwd_alu", 32'(ctl), 32'b00000);
    step();
    check("fwd_cnt", 32'(o_stall_count), 1);

    // Load feeding a taken branch: LU then BMM, then the flush
    idle(); i_id_is_branch = 1; i_id_branch_taken = 1; i_id_rs = 4;
    i_id_ex_mem_rd = 1; i_id_ex_wb = 1; i_id_ex_addr = 4; #1;
    check("ldbr_lu", 32'(ctl), 32'b11010);
    step();
    i_id_ex_mem_rd = 0; i_id_ex_wb = 0; i_id_ex_addr = 0;
    i_ex_mem_mem_rd = 1; i_ex_mem_addr = 4; #1;
    check("ldbr_bmm", 32'(ctl), 32'b11010);
    step();
    i_ex_mem_mem_rd = 0; i_ex_mem_addr = 0; #1;
    check("ldbr_flush", 32'(ctl), 32'b00100);
    check("ldbr_cnt", 32'(o_stall_count), 3);
    step();

    // Taken branch with an ALU producer in EX on rt
    idle(); i_id_is_branch = 1; i_id_branch_taken = 1; i_id_rs = 2; i_id_rt = 7;
    i_id_ex_wb = 1; i_id_ex_addr = 7; #1;
    check("bex_stall", 32'(ctl), 32'b11010);
    step();
    check("bex_cnt", 32'(o_stall_count), 4);
    i_id_ex_wb = 0; i_id_ex_addr = 0; #1;
    check("bex_flush", 32'(ctl), 32'b00100);
    step();

    // Disabled cycle masks the stall and freezes the counter
    idle(); i_enable = 0; i_id_ex_mem_rd = 1; i_id_ex_addr = 2; i_id_rs = 2; #1;
    check("dis_ctl", 32'(ctl), 32'b00000);
    step();
    check("dis_cnt", 32'(o_stall_count), 4);

    // HALT held behind a load-use, then drained
    idle(); i_id_halt = 1; i_id_ex_mem_rd = 1; i_id_ex_addr = 5; i_id_rt = 5; #1;
    check("halt_blk", 32'(ctl), 32'b11010);
    step();
    check("halt_blk_cnt", 32'(o_stall_count), 5);
    i_id_ex_mem_rd = 0; i_id_ex_addr = 0; #1;
    check("halt_go", 32'(ctl), 32'b11000);
    step();
    idle(); i_id_ex_mem_rd = 1; i_id_ex_addr = 6; i_id_rs = 6;
    i_id_is_branch = 1; i_id_branch_taken = 1; #1;
    check("drain_ctl", 32'(ctl), 32'b11010);
    step();
    check("drain_cnt", 32'(o_stall_count), 5);
    idle();
    step();
    check("drain_e3", 32'(ctl), 32'b11010);
    step();
    check("halted_e4", 32'(ctl), 32'b11011);
    step();
    check("halted_hold", 32'(ctl), 32'b11011);

    i_reset = 0; #1;
    check("rst_halted_ctl", 32'(ctl), 32'b00000);
    check("rst_halted_cnt", 32'(o_stall_count), 0);
    step();
    i_reset = 1;

    // Two disabled cycles mid-drain push o_halted out by two cycles
    idle(); i_id_halt = 1;
    step();
    idle();
    step();
    i_enable = 0;
    step();
    step();
    i_enable = 1; #1;
    check("gap_pre", 32'(ctl), 32'b11010);
    step();
    check("gap_e3", 32'(ctl), 32'b11010);
    step();
    check("gap_e4", 32'(ctl), 32'b11011);

    // Reset mid-drain
    i_reset = 0; #1;
    step();
    i_reset = 1;
    idle(); i_id_halt = 1;
    step();
    idle();
    step();
    check("mid_drain", 32'(ctl), 32'b11010);
    i_reset = 0; #1;
    check("mid_rst_ctl", 32'(ctl), 32'b00000);
    step();
    i_reset = 1; #1;
    step();
    check("post_rst_run", 32'(ctl), 32'b00000);

    // Saturation of the stall counter
    idle(); i_id_ex_mem_rd = 1; i_id_ex_addr = 9; i_id_rs = 9;
    for (int i = 0; i < (1 << Scs) + 5; i++) step();
    check("sat_cnt", 32'(o_stall_count), (1 << Scs) - 1);
    check("sat_ctl", 32'(ctl), 32'b11010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
